// File: rtl/vault_store_ctrl_pkg.sv
// vault_store_ctrl_pkg: op, status and FSM state encodings shared by the credential store
package vault_store_ctrl_pkg;
  typedef enum logic [1:0] {OP_STORE, OP_LOOKUP, OP_DELETE, OP_CLEAR} op_e;
  typedef enum logic [1:0] {ST_OK, ST_NOT_FOUND, ST_FULL, ST_UPDATED} status_e;
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_CIPHER, S_WRITE, S_RESP} state_e;
endpackage

// File: rtl/vault_store_ctrl_ram.sv
// vault_store_ctrl_ram: single-port write-first sync-read record RAM without reset
module vault_store_ctrl_ram #(
  parameter int W      = 256,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/vault_store_ctrl.sv
// vault_store_ctrl: credential store FSM scanning RAM records and driving an external cipher engine
module vault_store_ctrl
  import vault_store_ctrl_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_account,
  input  logic [DATA_W-1:0] cmd_password,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_password,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              enc_req,
  output logic              enc_mode,
  output logic [DATA_W-1:0] enc_din,
  input  logic              enc_ack,
  input  logic [DATA_W-1:0] enc_dout,
  output logic [ADDR_W:0]   used_count,
  output logic              full
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);
  state_e              state;
  op_e                 op;
  logic [DATA_W-1:0]   acct, pw, ctext;
  logic [ADDR_W:0]     s;
  logic [DEPTH-1:0]    valid;
  logic                have_free, new_rec;
  logic [ADDR_W-1:0]   free_slot, tgt, cmp, f_slot, ram_addr;
  logic [2*DATA_W-1:0] rd_data;
  logic                cmp_on, hit, cur_free, f_have, last, ram_we;
  always_comb begin
    cmp      = ADDR_W'(s - 1'b1);
    cmp_on   = state == S_SCAN && s != '0;
    hit      = cmp_on && valid[cmp] && rd_data[2*DATA_W-1:DATA_W] == acct;
    cur_free = cmp_on && !valid[cmp];
    f_have   = have_free || cur_free;
    f_slot   = have_free ? free_slot : cmp;
    last     = s == LAST;
    ram_we   = state == S_WRITE;
    ram_addr = ram_we ? tgt : (s < LAST ? s[ADDR_W-1:0] : '0);
  end
  assign cmd_ready = state == S_IDLE;
  assign full      = used_count == LAST;
  vault_store_ctrl_ram #(.W(2*DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata ({acct, ctext}),
    .rdata (rd_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op           <= OP_STORE;
      acct         <= '0;
      pw           <= '0;
      ctext        <= '0;
      s            <= '0;
      valid        <= '0;
      used_count   <= '0;
      have_free    <= 1'b0;
      new_rec      <= 1'b0;
      free_slot    <= '0;
      tgt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_status   <= ST_OK;
      rsp_password <= '0;
      rsp_addr     <= '0;
      enc_req      <= 1'b0;
      enc_mode     <= 1'b0;
      enc_din      <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op           <= op_e'(cmd_op);
          acct         <= cmd_account;
          pw           <= cmd_password;
          s            <= '0;
          have_free    <= 1'b0;
          rsp_status   <= ST_OK;
          rsp_password <= '0;
          rsp_addr     <= '0;
          if (cmd_op == OP_CLEAR) begin
            valid      <= '0;
            used_count <= '0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          s <= s + 1'b1;
          if (cur_free && !have_free) begin
            have_free <= 1'b1;
            free_slot <= cmp;
          end
          if (hit) begin
            tgt      <= cmp;
            rsp_addr <= cmp;
            if (op == OP_LOOKUP) begin
              enc_req  <= 1'b1;
              enc_mode <= 1'b1;
              enc_din  <= rd_data[DATA_W-1:0];
              state    <= S_CIPHER;
            end else if (op == OP_STORE) begin
              enc_req    <= 1'b1;
              enc_mode   <= 1'b0;
              enc_din    <= pw;
              new_rec    <= 1'b0;
              rsp_status <= ST_UPDATED;
              state      <= S_CIPHER;
            end else begin
              valid[cmp] <= 1'b0;
              used_count <= used_count - 1'b1;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end else if (last) begin
            if (op == OP_STORE && f_have) begin
              tgt      <= f_slot;
              rsp_addr <= f_slot;
              new_rec  <= 1'b1;
              enc_req  <= 1'b1;
              enc_mode <= 1'b0;
              enc_din  <= pw;
              state    <= S_CIPHER;
            end else begin
              rsp_status <= op == OP_STORE ? ST_FULL : ST_NOT_FOUND;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_CIPHER: if (enc_ack) begin
          enc_req <= 1'b0;
          if (op == OP_LOOKUP) begin
            rsp_password <= enc_dout;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            ctext <= enc_dout;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (new_rec) begin
            valid[tgt] <= 1'b1;
            used_count <= used_count + 1'b1;
          end
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vault_store_ctrl.sv
// tb_vault_store_ctrl: randomized and directed checks of vault_store_ctrl against a slot-array model
module tb_vault_store_ctrl;
  localparam int DW = 128;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam logic [DW-1:0] K = {16{8'hA5}};
  localparam logic [1:0] ST = 2'd0, LK = 2'd1, DL = 2'd2, CL = 2'd3;
  localparam logic [1:0] OK = 2'd0, NF = 2'd1, FU = 2'd2, UP = 2'd3;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0;
  logic [1:0] cmd_op = 2'd0, rsp_status;
  logic [DW-1:0] cmd_account = '0, cmd_password = '0, rsp_password, enc_din, enc_dout;
  logic [AW-1:0] rsp_addr;
  logic enc_req, enc_mode, enc_ack, full;
  logic [AW:0] used_count;
  int checks = 0, errors = 0;
  int req_cnt = 0, acnt = 0;
  bit hold_ack = 0;
  logic prev_req = 1'b0, last_mode = 1'b0;
  logic [DW-1:0] last_din = '0;
  logic [1:0] g_st, e_st;
  logic [DW-1:0] g_pw, e_pw;
  logic [AW-1:0] g_ad, e_ad;
  int g_lat, e_lat, e_used;
  logic [DW-1:0] m_acct [D];
  logic [DW-1:0] m_pw [D];
  bit m_v [D];
  always #5 clk = ~clk;
  vault_store_ctrl #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_account(cmd_account), .cmd_password(cmd_password), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_password(rsp_password),
    .rsp_addr(rsp_addr), .enc_req(enc_req), .enc_mode(enc_mode), .enc_din(enc_din),
    .enc_ack(enc_ack), .enc_dout(enc_dout), .used_count(used_count), .full(full)
  );
  initial begin
    enc_ack = 1'b0;
    enc_dout = '0;
    forever begin
      @(negedge clk);
      if (enc_req && !prev_req) begin
        req_cnt++;
        last_din = enc_din;
        last_mode = enc_mode;
      end
      prev_req = enc_req;
      if (enc_ack) begin
        enc_ack = 1'b0;
        acnt = 0;
      end else if (enc_req && !hold_ack) begin
        acnt++;
        if (acnt == 3) begin
          enc_ack = 1'b1;
          enc_dout = enc_din ^ K;
          acnt = 0;
        end
      end else begin
        acnt = 0;
      end
    end
  end
  task automatic model_clear();
    for (int i = 0; i < D; i++) m_v[i] = 0;
  endtask
  task automatic model_exec(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] p);
    int h, f;
    h = -1;
    f = -1;
    for (int i = D - 1; i >= 0; i--) begin
      if (m_v[i] && m_acct[i] == a) h = i;
      if (!m_v[i]) f = i;
    end
    e_st = OK;
    e_pw = '0;
    e_ad = '0;
    e_lat = -1;
    case (o)
      LK: if (h >= 0) begin
        e_pw = m_pw[h];
        e_ad = AW'(h);
      end else begin
        e_st = NF;
        e_lat = D + 2;
      end
      ST: if (h >= 0) begin
        m_pw[h] = p;
        e_st = UP;
        e_ad = AW'(h);
      end else if (f >= 0) begin
        m_v[f] = 1;
        m_acct[f] = a;
        m_pw[f] = p;
        e_ad = AW'(f);
      end else begin
        e_st = FU;
        e_lat = D + 2;
      end
      DL: if (h >= 0) begin
        m_v[h] = 0;
        e_ad = AW'(h);
        e_lat = h + 3;
      end else begin
        e_st = NF;
        e_lat = D + 2;
      end
      default: begin
        model_clear();
        e_lat = 1;
      end
    endcase
    e_used = 0;
    for (int i = 0; i < D; i++) e_used += int'(m_v[i]);
  endtask
  task automatic issue(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] p);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = o;
    cmd_account = a;
    cmd_password = p;
    @(negedge clk);
    cmd_valid = 1'b0;
    g_lat = 1;
    while (!rsp_valid && g_lat < 200) begin
      @(negedge clk);
      g_lat++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_timeout op=%0d got rsp_valid=%b want 1 within 200 cycles", o, rsp_valid);
    end
    g_st = rsp_status;
    g_pw = rsp_password;
    g_ad = rsp_addr;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_exec(o, a, p);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || used_count !== 3'd0 || full !== 1'b0 || rsp_valid !== 1'b0 || enc_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b used=%0d full=%b rv=%b req=%b want 1 0 0 0 0", cmd_ready, used_count, full, rsp_valid, enc_req);
    end
    issue(LK, 128'h11, '0);
    checks++;
    if (g_st !== NF || g_lat != 6 || g_ad !== '0 || g_pw !== '0) begin
      errors++;
      $display("FAIL reset_lookup got st=%0d lat=%0d addr=%0d want st=1 lat=6 addr=0", g_st, g_lat, g_ad);
    end
  endtask
  task automatic test_store_lookup();
    int r0;
    r0 = req_cnt;
    issue(ST, 128'h11, 128'h22);
    checks++;
    if (req_cnt != r0 + 1 || last_din !== 128'h22 || last_mode !== 1'b0) begin
      errors++;
      $display("FAIL store_cipher got reqs=%0d din=%h mode=%b want reqs=%0d din=22 mode=0", req_cnt - r0, last_din, last_mode, 1);
    end
    checks++;
    if (g_st !== OK || g_ad !== 2'd0 || used_count !== 3'd1) begin
      errors++;
      $display("FAIL store_rsp got st=%0d addr=%0d used=%0d want 0 0 1", g_st, g_ad, used_count);
    end
    issue(LK, 128'h11, '0);
    checks++;
    if (g_st !== OK || g_pw !== 128'h22 || g_ad !== 2'd0 || last_mode !== 1'b1 || last_din !== (128'h22 ^ K)) begin
      errors++;
      $display("FAIL lookup_hit got st=%0d pw=%h addr=%0d mode=%b want 0 22 0 1", g_st, g_pw, g_ad, last_mode);
    end
  endtask
  task automatic test_full();
    int r0;
    for (int i = 0; i < 3; i++) issue(ST, 128'h12 + DW'(i), 128'h1012 + DW'(i));
    checks++;
    if (full !== 1'b1 || used_count !== 3'd4) begin
      errors++;
      $display("FAIL fill got full=%b used=%0d want 1 4", full, used_count);
    end
    r0 = req_cnt;
    issue(ST, 128'h99, 128'h77);
    checks++;
    if (g_st !== FU || g_lat != 6 || req_cnt != r0 || used_count !== 3'd4) begin
      errors++;
      $display("FAIL store_full got st=%0d lat=%0d reqs=%0d used=%0d want 2 6 0 4", g_st, g_lat, req_cnt - r0, used_count);
    end
    issue(ST, 128'h11, 128'h33);
    checks++;
    if (g_st !== UP || g_ad !== 2'd0 || used_count !== 3'd4) begin
      errors++;
      $display("FAIL store_update got st=%0d addr=%0d used=%0d want 3 0 4", g_st, g_ad, used_count);
    end
    issue(LK, 128'h11, '0);
    checks++;
    if (g_st !== OK || g_pw !== 128'h33) begin
      errors++;
      $display("FAIL lookup_updated got st=%0d pw=%h want 0 33", g_st, g_pw);
    end
  endtask
  task automatic test_delete();
    issue(DL, 128'h12, '0);
    checks++;
    if (g_st !== OK || g_ad !== 2'd1 || g_lat != 4 || used_count !== 3'd3 || full !== 1'b0) begin
      errors++;
      $display("FAIL delete_hit got st=%0d addr=%0d lat=%0d used=%0d full=%b want 0 1 4 3 0", g_st, g_ad, g_lat, used_count, full);
    end
    issue(ST, 128'h55, 128'h66);
    checks++;
    if (g_st !== OK || g_ad !== 2'd1 || used_count !== 3'd4) begin
      errors++;
      $display("FAIL store_reuse got st=%0d addr=%0d used=%0d want 0 1 4", g_st, g_ad, used_count);
    end
    issue(DL, 128'h77, '0);
    checks++;
    if (g_st !== NF || g_lat != 6 || used_count !== 3'd4) begin
      errors++;
      $display("FAIL delete_miss got st=%0d lat=%0d used=%0d want 1 6 4", g_st, g_lat, used_count);
    end
  endtask
  task automatic test_backpressure();
    logic [1:0] s0;
    logic [DW-1:0] p0;
    logic [AW-1:0] a0;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = LK;
    cmd_account = 128'h13;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    s0 = rsp_status;
    p0 = rsp_password;
    a0 = rsp_addr;
    checks++;
    if (s0 !== OK || p0 !== 128'h1013 || a0 !== 2'd2) begin
      errors++;
      $display("FAIL bp_lookup got st=%0d pw=%h addr=%0d want 0 1013 2", s0, p0, a0);
    end
    cmd_op = CL;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = ~cmd_valid;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_status !== s0 || rsp_password !== p0 || rsp_addr !== a0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rv=%b rdy=%b st=%0d addr=%0d want 1 0 %0d %0d", i, rsp_valid, cmd_ready, rsp_status, rsp_addr, s0, a0);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (used_count !== 3'd4 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got used=%0d rv=%b rdy=%b want 4 0 1", used_count, rsp_valid, cmd_ready);
    end
  endtask
  task automatic test_random();
    logic [DW-1:0] pool [6];
    logic [1:0] o;
    logic [DW-1:0] a, p;
    int r, r0;
    pool[0] = '0;
    for (int i = 1; i < 6; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 19));
      o = r < 9 ? ST : r < 14 ? LK : r < 19 ? DL : CL;
      a = pool[$urandom_range(0, 5)];
      p = {$urandom, $urandom, $urandom, $urandom};
      r0 = req_cnt;
      issue(o, a, p);
      checks++;
      if (g_st !== e_st || g_pw !== e_pw || g_ad !== e_ad || int'(used_count) != e_used || (e_lat >= 0 && g_lat != e_lat)) begin
        errors++;
        $display("FAIL rand_rsp t=%0d op=%0d got st=%0d addr=%0d lat=%0d used=%0d want st=%0d addr=%0d lat=%0d used=%0d", t, o, g_st, g_ad, g_lat, used_count, e_st, e_ad, e_lat, e_used);
      end
      checks++;
      if (o == ST && e_st != FU) begin
        if (req_cnt != r0 + 1 || last_mode !== 1'b0 || last_din !== p) begin
          errors++;
          $display("FAIL rand_enc t=%0d got reqs=%0d mode=%b din=%h want 1 0 %h", t, req_cnt - r0, last_mode, last_din, p);
        end
      end else if (o == LK && e_st == OK) begin
        if (req_cnt != r0 + 1 || last_mode !== 1'b1 || last_din !== (e_pw ^ K)) begin
          errors++;
          $display("FAIL rand_dec t=%0d got reqs=%0d mode=%b din=%h want 1 1 %h", t, req_cnt - r0, last_mode, last_din, e_pw ^ K);
        end
      end else if (req_cnt != r0) begin
        errors++;
        $display("FAIL rand_noreq t=%0d got reqs=%0d want 0", t, req_cnt - r0);
      end
    end
  endtask
  task automatic test_reset_mid();
    int n;
    issue(CL, '0, '0);
    checks++;
    if (g_st !== OK || g_lat != 1 || used_count !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear got st=%0d lat=%0d used=%0d full=%b want 0 1 0 0", g_st, g_lat, used_count, full);
    end
    issue(ST, 128'h21, 128'h5);
    hold_ack = 1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = ST;
    cmd_account = 128'h31;
    cmd_password = 128'h6;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!enc_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (enc_req !== 1'b1 || used_count !== 3'd1) begin
      errors++;
      $display("FAIL mid_req got req=%b used=%0d want 1 1", enc_req, used_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (enc_req !== 1'b0 || used_count !== 3'd0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got req=%b used=%0d rdy=%b want 0 0 1", enc_req, used_count, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    hold_ack = 0;
    model_clear();
    issue(LK, 128'h21, '0);
    checks++;
    if (g_st !== NF || g_lat != 6) begin
      errors++;
      $display("FAIL post_reset_lookup got st=%0d lat=%0d want 1 6", g_st, g_lat);
    end
    issue(ST, 128'h41, 128'h8);
    issue(CL, '0, '0);
    checks++;
    if (g_st !== OK || g_lat != 1 || used_count !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL final_clear got st=%0d lat=%0d used=%0d full=%b want 0 1 0 0", g_st, g_lat, used_count, full);
    end
  endtask
  initial begin
    test_reset();
    test_store_lookup();
    test_full();
    test_delete();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
